// File: rtl/gpio_rx_pkg.sv
// gpio_rx_pkg: shared FSM state, default channel width and pixel layout
package gpio_rx_pkg;
   localparam int CHAN_W_DEF = 8;
   typedef enum logic [1:0] {WAIT_R, WAIT_G, WAIT_B} gpio_rx_state_t;
   typedef struct packed {
      logic [CHAN_W_DEF-1:0] r;
      logic [CHAN_W_DEF-1:0] g;
      logic [CHAN_W_DEF-1:0] b;
   } pixel_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: power-of-two synchronous FIFO; head reads as 0 while empty
module pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] dout
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level;
   logic          wr_en, rd_en;
   assign full  = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         level <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
endmodule

// File: rtl/gpio_pixel_receiver.sv
// gpio_pixel_receiver: assembles R/G/B GPIO strobes into pixels and queues them.
// Define GPIO_RX_ERRCNT_EN to build the saturating error counter behind err_cnt.
module gpio_pixel_receiver
   import gpio_rx_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int CHAN_W = CHAN_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           GPIO,
   input  logic                  GPIOEnR,
   input  logic                  GPIOEnG,
   input  logic                  GPIOEnB,
   input  logic                  pix_ready,
   output logic                  pix_valid,
   output logic [3*CHAN_W-1:0]   pix_data,
   output logic [CNT_W-1:0]      pix_count,
   output logic                  seq_err,
   output logic                  overflow,
   output logic [7:0]            err_cnt
);
   gpio_rx_state_t    state, state_nxt;
   logic [CHAN_W-1:0] r_q, g_q, chan;
   logic              ld_r, ld_g, push, err, pop, full, empty, accept;
   assign chan      = GPIO[CHAN_W-1:0];
   assign pix_valid = !empty;
   assign pop       = pix_valid && pix_ready;
   assign accept    = push && (!full || pop);
   generate
      if (CHAN_W < 32) begin : g_unused
         logic unused_gpio;
         assign unused_gpio = ^GPIO[31:CHAN_W];
      end
   endgenerate
   always_comb begin
      state_nxt = state;
      ld_r      = 1'b0;
      ld_g      = 1'b0;
      push      = 1'b0;
      err       = 1'b0;
      if (32'($countones({GPIOEnR, GPIOEnG, GPIOEnB})) > 32'd1) begin
         err       = 1'b1;
         state_nxt = WAIT_R;
      end else if (GPIOEnR) begin
         ld_r      = 1'b1;
         err       = state != WAIT_R;
         state_nxt = WAIT_G;
      end else if (GPIOEnG) begin
         ld_g      = state == WAIT_G;
         err       = !ld_g;
         state_nxt = ld_g ? WAIT_B : WAIT_R;
      end else if (GPIOEnB) begin
         push      = state == WAIT_B;
         err       = !push;
         state_nxt = WAIT_R;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= WAIT_R;
         r_q       <= '0;
         g_q       <= '0;
         pix_count <= '0;
         seq_err   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state    <= state_nxt;
         if (ld_r) r_q <= chan;
         if (ld_g) g_q <= chan;
         if (accept) pix_count <= pix_count + CNT_W'(1);
         seq_err  <= err;
         overflow <= push && full && !pop;
      end
   pixel_fifo #(.DEPTH(DEPTH), .W(3*CHAN_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   ({r_q, g_q, chan}),
      .full  (full),
      .empty (empty),
      .dout  (pix_data)
   );
`ifdef GPIO_RX_ERRCNT_EN
   logic [7:0] err_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_q <= '0;
      else if ((seq_err || overflow) && err_q != 8'hff) err_q <= err_q + 8'd1;
   assign err_cnt = err_q;
`else
   assign err_cnt = '0;
`endif
endmodule

// File: doc/gpio_pixel_receiver.md
GPIO_PIXEL_RECEIVER -- requirements
Module: gpio_pixel_receiver

Interface
REQ-001 Parameter DEPTH, default 4, sets the pixel FIFO depth; it SHALL be a power of two, 2..16.
REQ-002 Parameter CHAN_W, default 8, sets the channel width; it SHALL be sampled from GPIO[CHAN_W-1:0].
REQ-003 Parameter CNT_W, default 16, SHALL set the width of pix_count.
REQ-004 clk  in  1  the single clock; all logic SHALL be rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 GPIO  in  32  channel data word driven by the data memory's GPIO port.
REQ-007 GPIOEnR / GPIOEnG / GPIOEnB  in  1 each  single-cycle strobes marking GPIO as the R, G or B value.
REQ-008 pix_ready  in  1  downstream accepts a pixel.
REQ-009 pix_valid  out  1  FIFO head is valid.
REQ-010 pix_data  out  3*CHAN_W  {R,G,B} of the FIFO head.
REQ-011 pix_count  out  CNT_W  number of accepted pixels.
REQ-012 seq_err  out  1  one-cycle pulse on a protocol error.
REQ-013 overflow  out  1  one-cycle pulse when a pixel is dropped.
REQ-014 err_cnt  out  8  error counter, present in both builds (see Configuration).

Function
REQ-015 The FSM SHALL have three states: WAIT_R, WAIT_G and WAIT_B.
- WAIT_R + R strobe: latch R, go to WAIT_G.
- WAIT_G + G strobe: latch G, go to WAIT_B.
- WAIT_B + B strobe: push {R,G,B}, go to WAIT_R.
REQ-016 A single strobe that is not the one expected SHALL pulse seq_err and return to WAIT_R; if that strobe is R, it SHALL be latched and the FSM SHALL go to WAIT_G.
REQ-017 Two or more strobes in the same cycle SHALL pulse seq_err, latch nothing and force WAIT_R.
REQ-018 A cycle with no strobe SHALL hold the state; there SHALL be no timeout.
REQ-019 A pixel pushed into an empty FIFO at edge N SHALL show pix_valid=1 and pix_data at that pixel after edge N, i.e. one cycle of latency.
REQ-020 A pop SHALL occur on any edge where pix_valid and pix_ready are both 1; pix_data SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-021 A push while full SHALL be accepted only if a pop occurs in the same cycle; otherwise the pixel SHALL be dropped, overflow SHALL pulse and pix_count SHALL not change.
REQ-022 A push and a pop in the same cycle on a non-empty FIFO SHALL leave the level unchanged.
REQ-023 pix_count SHALL increment by 1 per accepted pixel and wrap from 2^CNT_W-1 to 0.
REQ-024 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-025 seq_err and overflow SHALL both pulse in the same cycle when both conditions hold.

Reset
REQ-026 While rst_n=0 the block SHALL be in WAIT_R, with the FIFO empty and the R/G latches at 0.
REQ-027 While rst_n=0 every output SHALL be 0: pix_valid, pix_data, pix_count, seq_err, overflow and err_cnt.
REQ-028 Reset asserted mid-triplet or with a non-empty FIFO SHALL discard all partial and queued data immediately, with no clock edge required.
REQ-029 Strobes on the first edge after rst_n rises SHALL be processed normally.

Configuration
REQ-030 With macro GPIO_RX_ERRCNT_EN defined, err_cnt SHALL increment by 1 on each cycle where seq_err or overflow pulses, and SHALL saturate at 255.
REQ-031 With GPIO_RX_ERRCNT_EN undefined, err_cnt SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-032 Package gpio_rx_pkg SHALL hold the FSM state enum (WAIT_R, WAIT_G, WAIT_B), the default CHAN_W and the packed pixel typedef.
REQ-033 Sub-module pixel_fifo SHALL implement the synchronous FIFO (push, pop, full, empty, head data), with the same clk and rst_n.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Triplet: R=0x11, G=0x22, B=0x33 on consecutive cycles with pix_ready=1 -> pix_valid one cycle after B, pix_data=0x112233, pix_count=1.
- Wrong order: strobe G first, then a full R/G/B triplet 0xAA/0xBB/0xCC -> one seq_err pulse, then pix_data=0xAABBCC.
- Simultaneous strobes: R and B in one cycle -> seq_err=1, FSM in WAIT_R, no push.
- Overflow: 5 triplets with pix_ready=0 and DEPTH=4 -> 4 stored, overflow pulses once, pix_count=4; then pix_ready=1 pops pixels 1-4 in order.
- Reset after R and G of a triplet, then B -> no pixel, seq_err pulse, pix_valid stays 0.
- With GPIO_RX_ERRCNT_EN: 300 error events -> err_cnt=255. Without the macro, the same stimulus -> err_cnt=0.
